// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad emulator.
// Key map packs {row[1:0], col[1:0]} per hex code.
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_PRESS,
      HOLD,
      BOUNCE_RELEASE,
      GAP
   } state_t;

   localparam logic [3:0] LINES_IDLE = 4'hF;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // nibble k = position of hex key k
   localparam logic [15:0][3:0] KEY_MAP =
      64'hECFB_73A9_8654_210D;

   function automatic logic [3:0] key_pos(
      input logic [3:0] code
   );
      return KEY_MAP[code];
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies
// the chatter pattern while a contact is bouncing.
module bounce_lfsr
   import keypad_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic bounce_bit
);

   logic [15:0] lfsr;
   logic        fb;

   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= LFSR_SEED;
      else if (en)
         lfsr <= {lfsr[14:0], fb};
   end

   assign bounce_bit = lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Matrix keypad emulator: presses one key per request.
// Define KEYPAD_BOUNCE_EN to add bounce windows around the hold.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES   = 96000,
   parameter int BOUNCE_CYCLES = 4800,
   parameter int GAP_CYCLES    = 48000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   input  logic [3:0] col_keys,
   output logic [3:0] row_keys,
   output logic       busy,
   output logic       done
);

   localparam int MAX_A =
      (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
   localparam int MAX_CYC =
      (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
   localparam int CW = $clog2(MAX_CYC) + 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t HOLD_LD = cnt_t'(HOLD_CYCLES - 1);
   localparam cnt_t GAP_LD  = cnt_t'(GAP_CYCLES - 1);

   state_t     state, state_n;
   cnt_t       cnt, cnt_n;
   logic [1:0] row_sel, col_sel;
   logic       contact;
   logic       last;

`ifdef KEYPAD_BOUNCE_EN
   localparam cnt_t BOUNCE_LD = cnt_t'(BOUNCE_CYCLES - 1);

   logic bounce_bit;

   bounce_lfsr u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .en         (1'b1),
      .bounce_bit (bounce_bit)
   );
`endif

   assign last = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         row_sel <= '0;
         col_sel <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (key_valid && key_ready)
            {row_sel, col_sel} <= key_pos(key_code);
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      key_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      contact   = 1'b0;
      unique case (state)
         IDLE: begin
            key_ready = 1'b1;
            busy      = 1'b0;
            if (key_valid) begin
`ifdef KEYPAD_BOUNCE_EN
               state_n = BOUNCE_PRESS;
               cnt_n   = BOUNCE_LD;
`else
               state_n = HOLD;
               cnt_n   = HOLD_LD;
`endif
            end
         end
`ifdef KEYPAD_BOUNCE_EN
         BOUNCE_PRESS: begin
            contact = bounce_bit;
            cnt_n   = cnt - 1'b1;
            if (last) begin
               state_n = HOLD;
               cnt_n   = HOLD_LD;
            end
         end
`endif
         HOLD: begin
            contact = 1'b1;
            cnt_n   = cnt - 1'b1;
            if (last) begin
`ifdef KEYPAD_BOUNCE_EN
               state_n = BOUNCE_RELEASE;
               cnt_n   = BOUNCE_LD;
`else
               state_n = GAP;
               cnt_n   = GAP_LD;
`endif
            end
         end
`ifdef KEYPAD_BOUNCE_EN
         BOUNCE_RELEASE: begin
            contact = bounce_bit;
            cnt_n   = cnt - 1'b1;
            if (last) begin
               state_n = GAP;
               cnt_n   = GAP_LD;
            end
         end
`endif
         GAP: begin
            cnt_n = cnt - 1'b1;
            if (last) begin
               state_n = IDLE;
               cnt_n   = '0;
               // an aborting reset must not report completion
               done    = !reset;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // reset releases the contact in the cycle it is asserted
   always_comb begin
      row_keys = LINES_IDLE;
      if (contact && !reset && !col_keys[col_sel])
         row_keys[row_sel] = 1'b0;
   end

endmodule
